// File: rtl/bp_pkg.sv
// Shared constants, types and helpers for the branch-predictor chooser slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bp_pkg;

   // RV32 conditional-branch major opcode (beq/bne/blt/bge/bltu/bgeu).
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Shape of the default chooser configuration (2 predictors, 2-bit counters).
   localparam int unsigned DFLT_NUM_PRED = 2;
   localparam int unsigned DFLT_CTR_BITS = 2;

   // One confidence counter and one chooser-table entry for the default shape.
   // bp_chooser declares a parameter-sized equivalent of the same layout so
   // that non-default configurations keep the identical packing.
   typedef logic [DFLT_CTR_BITS-1:0] ctr_t;
   typedef ctr_t [DFLT_NUM_PRED-1:0] entry_t;

   // Reset value of a confidence counter: the weakly-confident midpoint.
   function automatic int unsigned ctr_init(input int unsigned ctr_bits);
      return 32'd1 << (ctr_bits - 1);
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for an up/down counter that saturates at 0 and all-ones.
// Latency: combinational, zero cycles; the caller owns the register.
// Backpressure: none; clr wins over inc/dec, inc together with dec holds.
module bp_sat_ctr #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] cur,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] nxt
);

   localparam logic [W-1:0] CTR_MAX = '1;

   // Clear has priority; otherwise step once toward the requested end and stop there.
   always_comb begin
      nxt = cur;
      if (clr) begin
         nxt = '0;
      end else if (inc && !dec && (cur != CTR_MAX)) begin
         nxt = cur + W'(1);
      end else if (dec && !inc && (cur != '0)) begin
         nxt = cur - W'(1);
      end
   end

endmodule

// File: rtl/bp_chooser.sv
// Tournament chooser: per-PC confidence table picks a component predictor; scores resolves.
// Latency: lookup is combinational; training, hit flags and stats update one cycle after a resolve.
// Backpressure: none; a resolve can be accepted every cycle.
module bp_chooser
   import bp_pkg::*;
#(
   parameter int unsigned NUM_PRED  = 2,
   parameter int unsigned IDX_BITS  = 6,
   parameter int unsigned CTR_BITS  = 2,
   parameter int unsigned STAT_BITS = 32,
   localparam int unsigned SEL_W    = (NUM_PRED > 1) ? $clog2(NUM_PRED) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          lu_pc,
   input  logic [NUM_PRED-1:0]  lu_preds,
   output logic [SEL_W-1:0]     lu_sel,
   output logic                 lu_prediction,
   input  logic                 res_valid,
   input  logic [31:0]          res_inst,
   input  logic [31:0]          res_pc,
   input  logic                 res_taken,
   input  logic [NUM_PRED-1:0]  res_pred,
   input  logic                 res_final,
   input  logic                 clr_stats,
   output logic [NUM_PRED-1:0]  correct,
   output logic                 final_correct,
   output logic [STAT_BITS-1:0] branch_cnt,
   output logic [STAT_BITS-1:0] mispred_cnt
);

   localparam int unsigned DEPTH = 1 << IDX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

   // Parameter-sized version of the package entry layout.
   typedef logic [CTR_BITS-1:0]          chooser_ctr_t;
   typedef chooser_ctr_t [NUM_PRED-1:0]  chooser_entry_t;

   chooser_entry_t        tbl [DEPTH];

   logic                  armed;
   logic                  qual;
   logic [NUM_PRED-1:0]   hit;
   logic [IDX_BITS-1:0]   lu_idx;
   logic [IDX_BITS-1:0]   upd_idx;
   chooser_entry_t        lu_entry;
   chooser_entry_t        upd_entry;
   chooser_entry_t        upd_next;
   logic [STAT_BITS-1:0]  branch_nxt;
   logic [STAT_BITS-1:0]  mispred_nxt;
   logic                  mispredict;
   logic                  unused_bits;

   // PC bits outside the word-aligned index field do not take part in the table.
   assign unused_bits = ^{res_inst[31:7], res_pc[31:IDX_BITS+2], res_pc[1:0],
                          lu_pc[31:IDX_BITS+2], lu_pc[1:0]};

   // Only conditional branches train or count. Identity compares keep an
   // unknown opcode or valid from qualifying. 'armed' drops the resolve that
   // coincides with the first clock after reset release.
   assign qual       = armed && (res_valid === 1'b1) && (res_inst[6:0] === OPC_BRANCH);
   assign hit        = ~(res_pred ^ {NUM_PRED{res_taken}});
   assign mispredict = (res_final != res_taken);

   assign lu_idx    = lu_pc[IDX_BITS+1:2];
   assign upd_idx   = res_pc[IDX_BITS+1:2];
   assign lu_entry  = tbl[lu_idx];
   assign upd_entry = tbl[upd_idx];

   // Per-predictor training: agree with the outcome -> more confident, else less.
   for (genvar g = 0; g < NUM_PRED; g++) begin : g_train
      bp_sat_ctr #(.W(CTR_BITS)) u_ctr (
         .cur (upd_entry[g]),
         .inc (hit[g]),
         .dec (!hit[g]),
         .clr (1'b0),
         .nxt (upd_next[g])
      );
   end

   // Argmax over the looked-up counters; strict '>' keeps ties on the lowest index.
   always_comb begin
      chooser_ctr_t best_val;
      lu_sel   = '0;
      best_val = lu_entry[0];
      for (int i = 1; i < NUM_PRED; i++) begin
         if (lu_entry[i] > best_val) begin
            best_val = lu_entry[i];
            lu_sel   = SEL_W'(i);
         end
      end
   end

   assign lu_prediction = lu_preds[lu_sel];

   // Table write-back; lookup reads the array directly, so a same-index lookup sees old counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            tbl[k] <= {NUM_PRED{CTR_INIT}};
         end
      end else if (qual) begin
         tbl[upd_idx] <= upd_next;
      end
   end

   // Resolve gate: stays low through reset and the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   // Hit flags hold between branches; the final-prediction flag is a single-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         correct       <= '0;
         final_correct <= 1'b0;
      end else begin
         final_correct <= qual && !mispredict;
         if (qual) begin
            correct <= hit;
         end
      end
   end

   // Performance statistics: saturating, with clear taking priority over a count.
   bp_sat_ctr #(.W(STAT_BITS)) u_branch_stat (
      .cur (branch_cnt),
      .inc (qual),
      .dec (1'b0),
      .clr (clr_stats),
      .nxt (branch_nxt)
   );

   bp_sat_ctr #(.W(STAT_BITS)) u_mispred_stat (
      .cur (mispred_cnt),
      .inc (qual && mispredict),
      .dec (1'b0),
      .clr (clr_stats),
      .nxt (mispred_nxt)
   );

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         branch_cnt  <= branch_nxt;
         mispred_cnt <= mispred_nxt;
      end
   end

endmodule
